// File: rtl/sample_volume_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sample_volume_sequencer_pkg
// Shared definitions for the sample-volume sequencer:
//   - sequencer state encoding
//   - default counter widths (gate delay, volume length, volume count/index)
//   - minimum effective sample-volume length (a programmed 0 means 1)
// -----------------------------------------------------------------------------
package sample_volume_sequencer_pkg;

  localparam int DEF_DLY_W     = 16;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_VOL_W     = 8;

  // A zero-length volume makes no sense to the accumulator, so it is
  // promoted to this value when the line configuration is latched.
  localparam int MIN_SV_LENGTH = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sample_volume_sequencer.sv
// -----------------------------------------------------------------------------
// sample_volume_sequencer
// Per-line controller for the sample-volume accumulator path. A PRF trigger
// starts a line: after gate_delay cycles the sample stream is framed into
// num_volumes back-to-back volumes of sv_length samples each.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       sequencer enable; low aborts the current line
//   prf_trigger  single-cycle start-of-line pulse
//   gate_delay   cycles from trigger to the first sample of volume 0
//   sv_length    samples per volume (0 treated as 1)
//   num_volumes  volumes per line (0 completes the line immediately)
//   sv_valid     current sample belongs to a volume
//   sv_first     first sample of a volume (accumulator load)
//   sv_last      last sample of a volume (accumulator write)
//   sv_index     index of the current volume, qualified by sv_valid
//   line_busy    high from trigger acceptance until line end
//   line_done    one-cycle pulse at normal line completion
//   trig_overrun one-cycle pulse when a trigger arrives while busy
//
// All outputs are registered; the next-cycle values are computed together
// with the next state so that an output change lines up with its state.
// -----------------------------------------------------------------------------
module sample_volume_sequencer
  import sample_volume_sequencer_pkg::*;
#(
  parameter int DLY_W = DEF_DLY_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int VOL_W = DEF_VOL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             prf_trigger,
  input  logic [DLY_W-1:0] gate_delay,
  input  logic [LEN_W-1:0] sv_length,
  input  logic [VOL_W-1:0] num_volumes,
  output logic             sv_valid,
  output logic             sv_first,
  output logic             sv_last,
  output logic [VOL_W-1:0] sv_index,
  output logic             line_busy,
  output logic             line_done,
  output logic             trig_overrun
);

  seq_state_t       state_reg, state_next;
  logic [DLY_W-1:0] dly_cnt_reg, dly_cnt_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [VOL_W-1:0] nvol_reg, nvol_next;
  logic [LEN_W-1:0] samp_cnt_reg, samp_cnt_next;
  logic [VOL_W-1:0] sv_index_reg, sv_index_next;
  logic             sv_valid_reg, sv_valid_next;
  logic             sv_first_reg, sv_first_next;
  logic             sv_last_reg, sv_last_next;
  logic             line_busy_reg, line_busy_next;
  logic             line_done_reg, line_done_next;
  logic             trig_overrun_reg, trig_overrun_next;

  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] samp_cnt_inc;
  logic [LEN_W-1:0] len_m1;
  logic             len_is_one;
  logic             last_volume;

  assign len_in       = (sv_length == '0) ? LEN_W'(MIN_SV_LENGTH) : sv_length;
  assign samp_cnt_inc = samp_cnt_reg + LEN_W'(1);
  assign len_m1       = len_reg - LEN_W'(1);
  assign len_is_one   = (len_reg == LEN_W'(1));
  assign last_volume  = (sv_index_reg == nvol_reg - VOL_W'(1));

  always_comb begin
    state_next        = state_reg;
    dly_cnt_next      = dly_cnt_reg;
    len_next          = len_reg;
    nvol_next         = nvol_reg;
    samp_cnt_next     = samp_cnt_reg;
    sv_index_next     = sv_index_reg;
    sv_valid_next     = 1'b0;
    sv_first_next     = 1'b0;
    sv_last_next      = 1'b0;
    line_busy_next    = 1'b0;
    line_done_next    = 1'b0;
    trig_overrun_next = 1'b0;

    if (!enable) begin
      // Abort: everything clears, including the volume index, and a
      // coincident trigger is neither accepted nor reported as overrun.
      state_next    = ST_IDLE;
      dly_cnt_next  = '0;
      samp_cnt_next = '0;
      sv_index_next = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (prf_trigger) begin
            len_next      = len_in;
            nvol_next     = num_volumes;
            dly_cnt_next  = gate_delay;
            samp_cnt_next = '0;
            sv_index_next = '0;
            if (num_volumes == '0) begin
              state_next     = ST_DONE;
              line_done_next = 1'b1;
            end else if (gate_delay == '0) begin
              // No delay: the first sample is presented right away.
              state_next     = ST_ACCUM;
              line_busy_next = 1'b1;
              sv_valid_next  = 1'b1;
              sv_first_next  = 1'b1;
              sv_last_next   = (len_in == LEN_W'(1));
            end else begin
              state_next     = ST_DELAY;
              line_busy_next = 1'b1;
            end
          end
        end

        ST_DELAY: begin
          trig_overrun_next = prf_trigger;
          line_busy_next    = 1'b1;
          // dly_cnt holds the remaining delay cycles including this one.
          if (dly_cnt_reg <= DLY_W'(1)) begin
            state_next    = ST_ACCUM;
            dly_cnt_next  = '0;
            sv_valid_next = 1'b1;
            sv_first_next = 1'b1;
            sv_last_next  = len_is_one;
          end else begin
            dly_cnt_next = dly_cnt_reg - DLY_W'(1);
          end
        end

        ST_ACCUM: begin
          trig_overrun_next = prf_trigger;
          if (sv_last_reg) begin
            if (last_volume) begin
              state_next     = ST_DONE;
              samp_cnt_next  = '0;
              line_done_next = 1'b1;
            end else begin
              samp_cnt_next  = '0;
              sv_index_next  = sv_index_reg + VOL_W'(1);
              line_busy_next = 1'b1;
              sv_valid_next  = 1'b1;
              sv_first_next  = 1'b1;
              sv_last_next   = len_is_one;
            end
          end else begin
            samp_cnt_next  = samp_cnt_inc;
            line_busy_next = 1'b1;
            sv_valid_next  = 1'b1;
            sv_last_next   = (samp_cnt_inc == len_m1);
          end
        end

        ST_DONE: begin
          trig_overrun_next = prf_trigger;
          state_next        = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      dly_cnt_reg      <= '0;
      len_reg          <= '0;
      nvol_reg         <= '0;
      samp_cnt_reg     <= '0;
      sv_index_reg     <= '0;
      sv_valid_reg     <= 1'b0;
      sv_first_reg     <= 1'b0;
      sv_last_reg      <= 1'b0;
      line_busy_reg    <= 1'b0;
      line_done_reg    <= 1'b0;
      trig_overrun_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      dly_cnt_reg      <= dly_cnt_next;
      len_reg          <= len_next;
      nvol_reg         <= nvol_next;
      samp_cnt_reg     <= samp_cnt_next;
      sv_index_reg     <= sv_index_next;
      sv_valid_reg     <= sv_valid_next;
      sv_first_reg     <= sv_first_next;
      sv_last_reg      <= sv_last_next;
      line_busy_reg    <= line_busy_next;
      line_done_reg    <= line_done_next;
      trig_overrun_reg <= trig_overrun_next;
    end
  end

  assign sv_valid     = sv_valid_reg;
  assign sv_first     = sv_first_reg;
  assign sv_last      = sv_last_reg;
  assign sv_index     = sv_index_reg;
  assign line_busy    = line_busy_reg;
  assign line_done    = line_done_reg;
  assign trig_overrun = trig_overrun_reg;

endmodule

// File: tb/tb_sample_volume_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sample_volume_sequencer
// Table-driven bench. Each row is one line: its configuration plus the
// hand-computed cycle numbers (relative to the trigger cycle T=0) where
// sv_valid starts/ends and line_done pulses, with optional busy-trigger and
// abort cycles. Outputs are sampled on the falling edge; inputs for a cycle
// are applied right after sampling.
// -----------------------------------------------------------------------------
module tb_sample_volume_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        prf_trigger;
  logic [15:0] gate_delay;
  logic [7:0]  sv_length;
  logic [7:0]  num_volumes;
  logic        sv_valid;
  logic        sv_first;
  logic        sv_last;
  logic [7:0]  sv_index;
  logic        line_busy;
  logic        line_done;
  logic        trig_overrun;

  sample_volume_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .prf_trigger  (prf_trigger),
    .gate_delay   (gate_delay),
    .sv_length    (sv_length),
    .num_volumes  (num_volumes),
    .sv_valid     (sv_valid),
    .sv_first     (sv_first),
    .sv_last      (sv_last),
    .sv_index     (sv_index),
    .line_busy    (line_busy),
    .line_done    (line_done),
    .trig_overrun (trig_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gd;        // gate_delay
    int len;       // programmed sv_length
    int nv;        // num_volumes
    int len_eff;   // effective length (0 -> 1)
    int vstart;    // first cycle with sv_valid
    int vend;      // last cycle with sv_valid (vend < vstart: none)
    int done_at;   // cycle of line_done
    int trig_at;   // cycle with an extra trigger (0: none)
    int abort_at;  // cycle with enable low (0: none); low for 3 cycles
    int gap;       // idle cycles checked after the row
  } row_t;

  row_t rows[13];

  // flags = {sv_valid, sv_first, sv_last, line_busy, line_done, trig_overrun}
  task automatic chk_flags(input string name, input int k, input logic [5:0] exp);
    logic [5:0] act;
    act = {sv_valid, sv_first, sv_last, line_busy, line_done, trig_overrun};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d flags v/f/l/busy/done/ovr got %b want %b", name, k, act, exp);
    end
  endtask

  task automatic chk_index(input string name, input int k, input int exp);
    checks++;
    if (sv_index !== 8'(exp)) begin
      errors++;
      $display("FAIL %s cycle %0d sv_index got %0d want %0d", name, k, sv_index, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_flags("idle", i, 6'b0);
    end
  endtask

  // Starts at a falling edge (cycle 0 = trigger cycle), ends at a falling
  // edge after its last sample with the trigger low and enable high.
  task automatic run_row(input int ri);
    row_t r;
    int   last_k;
    bit   ab, ve, fe, le, be, de, oe;
    int   off;
    r = rows[ri];
    last_k = (r.abort_at != 0) ? r.abort_at + 3 : r.done_at + 1;
    enable      = 1'b1;
    prf_trigger = 1'b1;
    gate_delay  = 16'(r.gd);
    sv_length   = 8'(r.len);
    num_volumes = 8'(r.nv);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      ab  = (r.abort_at != 0) && (k > r.abort_at);
      ve  = !ab && (k >= r.vstart) && (k <= r.vend);
      off = k - r.vstart;
      fe  = ve && (off % r.len_eff == 0);
      le  = ve && (off % r.len_eff == r.len_eff - 1);
      be  = !ab && (k >= 1) && (k <= r.done_at - 1);
      de  = !ab && (k == r.done_at);
      oe  = (r.trig_at != 0) && (k == r.trig_at + 1) &&
            !((r.abort_at != 0) && (r.trig_at >= r.abort_at));
      chk_flags($sformatf("row%0d", ri), k, {ve, fe, le, be, de, oe});
      if (ve)
        chk_index($sformatf("row%0d", ri), k, off / r.len_eff);
      else if (ab)
        chk_index($sformatf("row%0d_abort", ri), k, 0);
      // inputs for cycle k; config changes after the latch must be ignored
      prf_trigger = (k == r.trig_at);
      enable      = !((r.abort_at != 0) && (k >= r.abort_at) && (k < last_k));
      if (k == 1) begin
        gate_delay  = 16'($urandom);
        sv_length   = 8'($urandom);
        num_volumes = 8'($urandom);
      end
    end
    prf_trigger = 1'b0;
    $display("row %0d gd=%0d len=%0d nv=%0d trig_at=%0d abort_at=%0d cycles=%0d checks=%0d errors=%0d",
             ri, r.gd, r.len, r.nv, r.trig_at, r.abort_at, last_k, checks, errors);
  endtask

  initial begin
    //          gd  len  nv eff vst vend done trig abort gap
    rows[0]  = '{3,   4,  2,  4,  4,  11, 12,   0,   0,  2};
    rows[1]  = '{0,   0,  3,  1,  1,   3,  4,   0,   0,  2};
    rows[2]  = '{0,   5,  0,  5,  1,   0,  1,   0,   0,  2};
    rows[3]  = '{2,   3,  1,  3,  3,   5,  6,   0,   0,  1};
    rows[4]  = '{1,   1,  1,  1,  2,   2,  3,   0,   0,  1};
    rows[5]  = '{0,   2,  2,  2,  1,   4,  5,   0,   0,  1};
    rows[6]  = '{3,   4,  2,  4,  4,  11, 12,   6,   0,  2};
    rows[7]  = '{3,   4,  2,  4,  4,  11, 12,  12,   0,  0};
    rows[8]  = '{0,   0,  3,  1,  1,   3,  4,   0,   0,  2};
    rows[9]  = '{3,   4,  2,  4,  4,  11, 12,   0,   6,  2};
    rows[10] = '{3,   4,  2,  4,  4,  11, 12,   0,   0,  2};
    rows[11] = '{3,   4,  2,  4,  4,  11, 12,   6,   6,  2};
    rows[12] = '{0, 255,  1, 255, 1, 255, 256,  0,   0,  2};

    reset       = 1'b0;
    enable      = 1'b0;
    prf_trigger = 1'b0;
    gate_delay  = '0;
    sv_length   = '0;
    num_volumes = '0;

    repeat (2) @(negedge clk);
    chk_flags("reset", 0, 6'b0);
    chk_index("reset", 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_flags("post_reset", 0, 6'b0);
    enable = 1'b1;

    for (int ri = 0; ri < 13; ri++) begin
      run_row(ri);
      idle_cycles(rows[ri].gap);
    end

    // Asynchronous reset in the middle of ACCUM, between clock edges.
    enable      = 1'b1;
    prf_trigger = 1'b1;
    gate_delay  = 16'd3;
    sv_length   = 8'd4;
    num_volumes = 8'd2;
    @(negedge clk);
    prf_trigger = 1'b0;
    repeat (5) @(negedge clk);
    chk_flags("pre_async", 6, 6'b100100);
    chk_index("pre_async", 6, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_flags("async_reset", 7, 6'b0);
    chk_index("async_reset", 7, 0);
    @(negedge clk);
    chk_flags("async_hold", 7, 6'b0);
    reset = 1'b1;
    $display("async reset mid-line checks=%0d errors=%0d", checks, errors);
    run_row(0);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_volume_sequencer.md
Name: sample_volume_sequencer

Overview:
- Per-line controller for the sample-volume accumulator path.
- On each pulse-repetition trigger it waits a programmable range-gate delay. It then frames the incoming baseband sample stream into num_volumes consecutive sample volumes of sv_length samples each.
- Emits valid/first/last strobes and a volume index that drive the accumulator's load/accumulate/write decisions.
- Sits between the PRF timing generator and the accumulator.

Parameters:
- DLY_W, 16, width of gate-delay counter.
- LEN_W, 8, width of sample-volume length.
- VOL_W, 8, width of volume count/index.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  sequencer enable; low aborts the current line
- prf_trigger  in  1  single-cycle start-of-line pulse
- gate_delay  in  DLY_W  cycles from trigger to first sample of volume 0
- sv_length  in  LEN_W  samples per volume; 0 treated as 1
- num_volumes  in  VOL_W  volumes per line
- sv_valid  out  1  current sample belongs to a volume
- sv_first  out  1  first sample of a volume (accumulator loads)
- sv_last  out  1  last sample of a volume (accumulator result written)
- sv_index  out  VOL_W  index of the current volume
- line_busy  out  1  high from trigger acceptance until line end
- line_done  out  1  one-cycle pulse at normal line completion
- trig_overrun  out  1  one-cycle pulse when a trigger arrives while busy

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; counters 0.
- States: IDLE, DELAY, ACCUM, DONE. All outputs are registered.
- IDLE:
  - On prf_trigger & enable at edge T: latch gate_delay, sv_length (0→1) and num_volumes into shadow registers.
  - Then go to DELAY and set line_busy=1 from T+1.
  - Config inputs are ignored outside that latch edge.
- Zero volumes: if latched num_volumes==0, go straight to DONE instead of DELAY. line_done pulses at T+1; no sv_valid.
- DELAY:
  - Count latched gate_delay cycles, then enter ACCUM.
  - The first sv_valid is at cycle T+1+gate_delay, so gate_delay=0 gives the first sample at T+1.
- ACCUM:
  - sv_valid=1 every cycle.
  - Sample counter runs 0..len-1. sv_first=1 at count 0; sv_last=1 at count len-1. With len=1 both are high together.
  - After sv_last, the sample counter wraps to 0 and sv_index increments.
  - When sv_last coincides with sv_index==num_volumes-1, go to DONE.
  - Total ACCUM cycles = len*num_volumes; no gap between volumes.
- DONE: line_done=1 for one cycle; line_busy and sv_* are 0; then IDLE.
  - A trigger in the DONE cycle counts as overrun.
  - A trigger in the cycle after DONE (IDLE) is accepted.
- Busy trigger: prf_trigger while state≠IDLE → trig_overrun pulses the next cycle. The line continues unaffected and the trigger is discarded.
- Abort: enable=0 in any state forces IDLE at the next edge. All outputs clear; no line_done. A trigger is not accepted while enable=0.
- Simultaneous enable=0 and trigger: abort wins; no overrun pulse.
- Counters do not wrap across lines. sv_index resets to 0 on each accepted trigger.
- sv_index holds its last value outside ACCUM, but is qualified only by sv_valid.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE/DELAY/ACCUM/DONE);
  - default widths DLY_W/LEN_W/VOL_W;
  - constant for the minimum sv_length (1).
- No sub-module is needed. The sample/volume counter pair can be a small internal generic counter (sv_frame_counter) if the team reuses it in the display decimator; otherwise keep it inline.

Test Plan:
- gate_delay=3, sv_length=4, num_volumes=2, trigger at T:
  - sv_valid T+4..T+11;
  - sv_first at T+4, T+8; sv_last at T+7, T+11;
  - sv_index 0 then 1;
  - line_done at T+12; line_busy T+1..T+11.
- gate_delay=0, sv_length=0 (treated as 1), num_volumes=3 → sv_valid T+1..T+3, with sv_first=sv_last=1 each cycle and sv_index 0,1,2; line_done at T+4.
- num_volumes=0 → line_done at T+1, no sv_valid, line_busy never asserts beyond the DONE cycle.
- Second prf_trigger at T+6 during the first line → trig_overrun at T+7; the first line completes identically to scenario 1.
- enable deasserted at T+6 of scenario 1 → all outputs 0 from T+7, no line_done; the next trigger with enable=1 starts a fresh line with sv_index=0.
- Async reset asserted mid-ACCUM (between edges) → outputs 0 immediately. After release, a trigger starts a normal line with the first sv_valid at T+1+gate_delay.
